// File: rtl/cdu_fine_read_counter.sv
// cdu_fine_read_counter
// Closes the CDU fine read loop. The fine and high-ternary Schmitt outputs
// and the error sign are synchronised. A 7-bit fine counter is stepped toward
// null. The counter bits drive the active-low ladder switch lines _D15.._D21.
// Each step emits a one-clock count pulse. A wrap emits a carry/borrow pulse.
module cdu_fine_read_counter #(
  parameter int LO_PERIOD = 16,  // clocks from WAIT entry to count, low speed
  parameter int HI_PERIOD = 1,   // clocks from WAIT entry to count, high speed
  parameter int SETTLE    = 4,   // ladder settling blank after each count
  parameter int RW        = 16   // rate/settle down-counter width
) (
  input  logic clk,
  input  logic rst_n,
  input  logic _TLF1H,
  input  logic _TLF2H,
  input  logic ERRSGN,
  input  logic ZERO,
  output logic _D15,
  output logic _D16,
  output logic _D17,
  output logic _D18,
  output logic _D19,
  output logic _D20,
  output logic _D21,
  output logic CNTUP,
  output logic CNTDN,
  output logic CRYUP,
  output logic CRYDN
);

  // ------------------------------------------------------------------------
  // Constants
  // ------------------------------------------------------------------------
  localparam int NSYNC = 3;

  // Synchroniser lane order: [2] _TLF1H, [1] _TLF2H, [0] ERRSGN.
  // Reset value is the no-error condition: both Schmitts high, sign positive.
  localparam logic [NSYNC-1:0] SYNC_IDLE = 3'b110;

  // Down-counter reload values. Each phase lasts reload+1 clocks.
  localparam logic [RW-1:0] LO_LOAD     = RW'(LO_PERIOD - 1);
  localparam logic [RW-1:0] HI_LOAD     = RW'(HI_PERIOD - 1);
  localparam logic [RW-1:0] SETTLE_LOAD = RW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // ------------------------------------------------------------------------
  // Signals
  // ------------------------------------------------------------------------
  logic [NSYNC-1:0] async_vec;
  logic [NSYNC-1:0] sync_vec;
  logic             fine;
  logic             coarse;
  logic             dn;

  state_t           state_reg;
  state_t           state_next;
  logic [RW-1:0]    rcnt_reg;
  logic [RW-1:0]    rcnt_next;
  logic             count_edge;

  logic [6:0]       c_reg;
  logic [6:0]       c_next;
  logic             cntup_reg;
  logic             cntup_next;
  logic             cntdn_reg;
  logic             cntdn_next;
  logic             cryup_reg;
  logic             cryup_next;
  logic             crydn_reg;
  logic             crydn_next;

  // ------------------------------------------------------------------------
  // Input synchronisers
  // ------------------------------------------------------------------------
  assign async_vec = {_TLF1H, _TLF2H, ERRSGN};

  genvar gi;
  generate
    for (gi = 0; gi < NSYNC; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      // Two-flop synchroniser for one asynchronous comparator output.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg <= SYNC_IDLE[gi];
          sync_reg <= SYNC_IDLE[gi];
        end else begin
          meta_reg <= async_vec[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_vec[gi] = sync_reg;
    end
  endgenerate

  // The Schmitt outputs are active-low. The sign is 1 for a negative error.
  assign fine   = ~sync_vec[2];
  assign coarse = ~sync_vec[1];
  assign dn     =  sync_vec[0];

  // ------------------------------------------------------------------------
  // Loop sequencer: IDLE -> WAIT (rate delay) -> count -> SETTLE (blank)
  // ------------------------------------------------------------------------

  // State and rate/settle down-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      rcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rcnt_reg  <= rcnt_next;
    end
  end

  // Next-state logic. This also decides the count edge.
  always_comb begin
    state_next = state_reg;
    rcnt_next  = rcnt_reg;
    count_edge = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (fine) begin
          state_next = ST_WAIT;
          rcnt_next  = coarse ? HI_LOAD : LO_LOAD;
        end
      end

      ST_WAIT: begin
        if (!fine) begin
          // The error fell inside the fine threshold before the count.
          state_next = ST_IDLE;
        end else if (coarse && (rcnt_reg > HI_LOAD)) begin
          // A large error seen mid-wait shortens the remaining delay.
          rcnt_next = HI_LOAD;
        end else if (rcnt_reg == '0) begin
          count_edge = 1'b1;
          state_next = ST_SETTLE;
          rcnt_next  = SETTLE_LOAD;
        end else begin
          rcnt_next = rcnt_reg - RW'(1);
        end
      end

      ST_SETTLE: begin
        // Let the ladder settle. The Schmitts are not trusted here.
        if (rcnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          rcnt_next = rcnt_reg - RW'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        rcnt_next  = '0;
      end
    endcase

    // A zero command parks the sequencer and cancels any pending count.
    if (ZERO) begin
      state_next = ST_IDLE;
      rcnt_next  = '0;
      count_edge = 1'b0;
    end
  end

  // Output logic: the counter update and its pulses for this edge.
  always_comb begin
    c_next     = c_reg;
    cntup_next = 1'b0;
    cntdn_next = 1'b0;
    cryup_next = 1'b0;
    crydn_next = 1'b0;

    if (ZERO) begin
      c_next = '0;
    end else if (count_edge) begin
      if (dn) begin
        c_next     = c_reg - 7'd1;
        cntdn_next = 1'b1;
        crydn_next = (c_reg == 7'd0);
      end else begin
        c_next     = c_reg + 7'd1;
        cntup_next = 1'b1;
        cryup_next = (c_reg == 7'd127);
      end
    end
  end

  // Fine counter and registered pulses. The pulses line up with the new count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg     <= '0;
      cntup_reg <= 1'b0;
      cntdn_reg <= 1'b0;
      cryup_reg <= 1'b0;
      crydn_reg <= 1'b0;
    end else begin
      c_reg     <= c_next;
      cntup_reg <= cntup_next;
      cntdn_reg <= cntdn_next;
      cryup_reg <= cryup_next;
      crydn_reg <= crydn_next;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  // The ladder switches are active-low. _D15 is the MSB.
  assign {_D15, _D16, _D17, _D18, _D19, _D20, _D21} = ~c_reg;

  assign CNTUP = cntup_reg;
  assign CNTDN = cntdn_reg;
  assign CRYUP = cryup_reg;
  assign CRYDN = crydn_reg;

endmodule

// File: tb/tb_cdu_fine_read_counter.sv
// Directed bench for cdu_fine_read_counter with the default parameters.
// The expected pulse spacings and latencies are computed by hand from the
// synchroniser delay (2 clocks) and the IDLE/WAIT/SETTLE timing.
module tb_cdu_fine_read_counter;

  logic clk = 1'b0;
  logic rst_n;
  logic _TLF1H, _TLF2H, ERRSGN, ZERO;
  logic _D15, _D16, _D17, _D18, _D19, _D20, _D21;
  logic CNTUP, CNTDN, CRYUP, CRYDN;

  int errors = 0;
  int checks = 0;
  int exp_c;
  int n;
  int cnt;

  always #5 clk = ~clk;

  cdu_fine_read_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    ._TLF1H(_TLF1H),
    ._TLF2H(_TLF2H),
    .ERRSGN(ERRSGN),
    .ZERO  (ZERO),
    ._D15  (_D15),
    ._D16  (_D16),
    ._D17  (_D17),
    ._D18  (_D18),
    ._D19  (_D19),
    ._D20  (_D20),
    ._D21  (_D21),
    .CNTUP (CNTUP),
    .CNTDN (CNTDN),
    .CRYUP (CRYUP),
    .CRYDN (CRYDN)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  function automatic int raw_d();
    logic [6:0] v;
    v = {_D15, _D16, _D17, _D18, _D19, _D20, _D21};
    return int'(v);
  endfunction

  function automatic int c_val();
    logic [6:0] v;
    v = ~{_D15, _D16, _D17, _D18, _D19, _D20, _D21};
    return int'(v);
  endfunction

  // Step negedges until a count pulse is seen. On timeout, n = limit+1.
  task automatic wait_pulse(input int limit, output int n_out);
    n_out = 0;
    forever begin
      @(negedge clk);
      n_out++;
      if (CNTUP || CNTDN) break;
      if (n_out > limit) break;
    end
  endtask

  // Count the cycles with any pulse high over a window of negedges.
  task automatic count_pulses(input int cycles, output int cnt_out);
    cnt_out = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (CNTUP || CNTDN || CRYUP || CRYDN) cnt_out++;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    _TLF1H = 1'b1;
    _TLF2H = 1'b1;
    ERRSGN = 1'b0;
    ZERO   = 1'b0;

    // ---- 1: reset and idle -------------------------------------------------
    repeat (3) @(negedge clk);
    check("rst_ladder", raw_d(), 127);
    check("rst_pulses", int'({CNTUP, CNTDN, CRYUP, CRYDN}), 0);
    rst_n = 1'b1;
    count_pulses(100, cnt);
    check("idle_pulses", cnt, 0);
    check("idle_ladder", raw_d(), 127);

    // ---- 2: low-speed counting up ------------------------------------------
    _TLF1H = 1'b0;
    wait_pulse(40, n);
    check("lo_first_lat", n, 19);
    check("lo_first_up", int'(CNTUP), 1);
    check("lo_first_c", c_val(), 1);
    exp_c = 1;
    for (int k = 2; k <= 4; k++) begin
      wait_pulse(40, n);
      exp_c++;
      check("lo_spacing", n, 21);
      check("lo_c", c_val(), exp_c);
      check("lo_d21", int'(_D21), (exp_c % 2 == 1) ? 0 : 1);
    end

    // ---- 3: high-speed counting, then the clamp ----------------------------
    _TLF2H = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_pulse(40, n);
      exp_c++;
      check("hi_spacing", n, 6);
      check("hi_c", c_val(), exp_c);
    end
    _TLF2H = 1'b1;
    wait_pulse(40, n);
    exp_c++;
    check("back_lo_spacing", n, 21);
    check("back_lo_c", c_val(), exp_c);
    repeat (8) @(negedge clk);
    _TLF2H = 1'b0;
    wait_pulse(40, n);
    exp_c++;
    check("clamp_lat", n, 4);
    check("clamp_c", c_val(), exp_c);

    // ---- 4: wrap up, then wrap down ----------------------------------------
    while (exp_c < 127) begin
      wait_pulse(10, n);
      exp_c++;
      check("fill_c", c_val(), exp_c);
      if (n > 10) break;
    end
    wait_pulse(10, n);
    check("wrapup_spacing", n, 6);
    check("wrapup_c", c_val(), 0);
    check("wrapup_cntup", int'(CNTUP), 1);
    check("wrapup_cryup", int'(CRYUP), 1);
    check("wrapup_crydn", int'(CRYDN), 0);
    ERRSGN = 1'b1;
    wait_pulse(10, n);
    check("wrapdn_spacing", n, 6);
    check("wrapdn_c", c_val(), 127);
    check("wrapdn_cntdn", int'(CNTDN), 1);
    check("wrapdn_crydn", int'(CRYDN), 1);
    check("wrapdn_cntup", int'(CNTUP), 0);
    check("wrapdn_cryup", int'(CRYUP), 0);

    // ---- 5: short fine excursion gives no count ----------------------------
    _TLF1H = 1'b1;
    _TLF2H = 1'b1;
    count_pulses(30, cnt);
    check("stop_pulses", cnt, 0);
    _TLF1H = 1'b0;
    repeat (10) @(negedge clk);
    _TLF1H = 1'b1;
    count_pulses(40, cnt);
    check("short_pulses", cnt, 0);
    check("short_c", c_val(), 127);

    // ---- 6: ZERO on the count edge, ZERO held, reset in SETTLE -------------
    ERRSGN = 1'b0;
    _TLF1H = 1'b0;
    _TLF2H = 1'b0;
    repeat (3) @(negedge clk);
    ZERO = 1'b1;
    @(negedge clk);
    ZERO = 1'b0;
    check("zero_c", c_val(), 0);
    check("zero_pulses", int'({CNTUP, CNTDN, CRYUP, CRYDN}), 0);
    wait_pulse(10, n);
    check("after_zero_lat", n, 2);
    check("after_zero_c", c_val(), 1);

    ZERO = 1'b1;
    count_pulses(30, cnt);
    check("zero_hold_pulses", cnt, 0);
    check("zero_hold_c", c_val(), 0);
    ZERO = 1'b0;
    wait_pulse(10, n);
    check("zero_release_lat", n, 2);
    check("zero_release_c", c_val(), 1);

    // This negedge is right after a count edge, so the state is SETTLE.
    rst_n = 1'b0;
    #1;
    check("settle_rst_ladder", raw_d(), 127);
    check("settle_rst_pulses", int'({CNTUP, CNTDN, CRYUP, CRYDN}), 0);
    count_pulses(3, cnt);
    check("in_rst_pulses", cnt, 0);
    _TLF1H = 1'b1;
    _TLF2H = 1'b1;
    rst_n  = 1'b1;
    count_pulses(20, cnt);
    check("post_rst_pulses", cnt, 0);
    check("post_rst_ladder", raw_d(), 127);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
